m_store_buf: RTL and testbench

M_STORE_BUF -- requirements
Module: m_store_buf

---
 rtl/m_store_buf.sv | 171 +++++++++++++++++
 tb/tb_m_store_buf.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_store_buf.sv
// m_store_buf: single-entry store buffer that sits between the M stage and the
// data bus. It turns SW/SH/SB requests into word-aligned bus writes with byte
// enables and replicated write data. It also raises a one-cycle address-error
// exception for stores that are misaligned, outside the mapped regions, or
// that target timer registers a store may not write.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   req_valid, store_op        M-stage store request (00 SW, 01 SH, 10 SB, 11 no-op)
//   req_addr, req_wdata        byte address and register data of the store
//   req_pc                     PC of the store, reported on an exception
//   flush                      cancels the M-stage request this cycle
//   req_ready                  buffer can take a request this cycle
//   m_valid, m_addr, m_wdata,
//   m_byteen, m_ready          bus write request and handshake
//   exc_ades, exc_pc           store address exception and faulting PC
//
// state | meaning
// IDLE  | no buffered write, m_valid low
// BUSY  | buffered write presented on the bus until m_ready

module m_store_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  store_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    input  logic        flush,
    output logic        req_ready,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_byteen,
    input  logic        m_ready,
    output logic        exc_ades,
    output logic [31:0] exc_pc
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_byteen;
    logic        r_exc_ades;
    logic [31:0] r_exc_pc;

    logic        w_req_ready;
    logic        w_accept;
    logic        w_op_sw;
    logic        w_op_sh;
    logic        w_op_nop;
    logic        w_in_ram;
    logic        w_in_tmr;
    logic        w_in_misc;
    logic        w_in_cnt;
    logic        w_misalign;
    logic        w_illegal;
    logic        w_do_write;
    logic        w_do_exc;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata;

    assign w_op_sw  = (store_op == 2'b00);
    assign w_op_sh  = (store_op == 2'b01);
    assign w_op_nop = (store_op == 2'b11);

    assign w_in_ram  = (req_addr <= 32'h0000_2FFF);
    assign w_in_tmr  = ((req_addr >= 32'h0000_7F00) && (req_addr <= 32'h0000_7F0B)) ||
                       ((req_addr >= 32'h0000_7F10) && (req_addr <= 32'h0000_7F1B));
    assign w_in_misc = (req_addr >= 32'h0000_7F20) && (req_addr <= 32'h0000_7F23);
    // Timer COUNT registers are read-only to stores.
    assign w_in_cnt  = ((req_addr >= 32'h0000_7F08) && (req_addr <= 32'h0000_7F0B)) ||
                       ((req_addr >= 32'h0000_7F18) && (req_addr <= 32'h0000_7F1B));

    assign w_misalign = (w_op_sw && (req_addr[1:0] != 2'b00)) || (w_op_sh && req_addr[0]);
    // Timers only accept full-word stores.
    assign w_illegal  = w_misalign || !(w_in_ram || w_in_tmr || w_in_misc) ||
                        (w_in_tmr && !w_op_sw) || w_in_cnt;

    // In BUSY a new store can only be taken when the held write drains this cycle.
    assign w_req_ready = (r_state == S_IDLE) || m_ready;
    assign req_ready   = w_req_ready;
    assign w_accept    = req_valid && w_req_ready && !flush;
    assign w_do_write  = w_accept && !w_op_nop && !w_illegal;
    assign w_do_exc    = w_accept && !w_op_nop && w_illegal;

    always_comb begin
        w_byteen = 4'b0000;
        w_wdata  = 32'h0;
        unique case (store_op)
            2'b00: begin
                w_byteen = 4'b1111;
                w_wdata  = req_wdata;
            end
            2'b01: begin
                w_byteen = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata  = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                w_byteen = 4'b0001 << req_addr[1:0];
                w_wdata  = {4{req_wdata[7:0]}};
            end
            default: begin
                w_byteen = 4'b0000;
                w_wdata  = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        m_valid      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_do_write) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                m_valid = 1'b1;
                if (w_do_write) begin
                    w_next_state = S_BUSY;
                end else if (m_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_byteen   <= 4'b0000;
            r_exc_ades <= 1'b0;
            r_exc_pc   <= 32'h0;
        end else begin
            if (w_do_write) begin
                r_addr   <= {req_addr[31:2], 2'b00};
                r_wdata  <= w_wdata;
                r_byteen <= w_byteen;
            end
            r_exc_ades <= w_do_exc;
            if (w_do_exc) begin
                r_exc_pc <= req_pc;
            end
        end
    end

    assign m_addr   = r_addr;
    assign m_wdata  = r_wdata;
    assign m_byteen = r_byteen;
    assign exc_ades = r_exc_ades;
    assign exc_pc   = r_exc_pc;

endmodule

// File: tb/tb_m_store_buf.sv
// Testbench for m_store_buf: directed scenarios followed by random stores,
// all checked against a transaction-level reference model.

module tb_m_store_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  store_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        flush;
    logic        req_ready;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byteen;
    logic        m_ready;
    logic        exc_ades;
    logic [31:0] exc_pc;

    int checks = 0;
    int errors = 0;

    // Reference model: what the bus and exception outputs should show.
    bit          mdl_busy;
    logic [31:0] mdl_addr;
    logic [31:0] mdl_wdata;
    logic [3:0]  mdl_be;
    bit          mdl_exc;
    logic [31:0] mdl_pc;

    m_store_buf dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .store_op  (store_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .flush     (flush),
        .req_ready (req_ready),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_byteen  (m_byteen),
        .m_ready   (m_ready),
        .exc_ades  (exc_ades),
        .exc_pc    (exc_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a, input int unsigned lo, input int unsigned hi);
        return (a >= lo) && (a <= hi);
    endfunction

    function automatic bit is_legal(input logic [1:0] op, input logic [31:0] a);
        bit timer;
        timer = in_rng(a, 'h7F00, 'h7F1B) && !in_rng(a, 'h7F0C, 'h7F0F);
        if (op == 2'd0 && (a % 4) != 0) return 0;
        if (op == 2'd1 && (a % 2) != 0) return 0;
        if (!(in_rng(a, 0, 'h2FFF) || timer || in_rng(a, 'h7F20, 'h7F23))) return 0;
        if (timer && op != 2'd0) return 0;
        if (in_rng(a, 'h7F08, 'h7F0B) || in_rng(a, 'h7F18, 'h7F1B)) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        mdl_busy  = 0;
        mdl_addr  = 32'h0;
        mdl_wdata = 32'h0;
        mdl_be    = 4'h0;
        mdl_exc   = 0;
        mdl_pc    = 32'h0;
    endtask

    // One clock cycle: called at a falling edge, returns at the next falling edge.
    task automatic step(input bit v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] pc,
                        input bit fl, input bit mr);
        bit exp_ready;
        bit acc;
        bit legal;
        req_valid = v;
        store_op  = op;
        req_addr  = a;
        req_wdata = w;
        req_pc    = pc;
        flush     = fl;
        m_ready   = mr;
        #1;
        exp_ready = mdl_busy ? mr : 1'b1;
        chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
        acc   = v && exp_ready && !fl;
        legal = is_legal(op, a);
        if (acc && op != 2'd3 && legal) begin
            mdl_busy = 1;
            mdl_addr = a - (a % 4);
            case (op)
                2'd0: begin mdl_be = 4'hF; mdl_wdata = w; end
                2'd1: begin
                    mdl_be    = ((a % 4) >= 2) ? 4'hC : 4'h3;
                    mdl_wdata = (w % 32'h1_0000) * 32'h0001_0001;
                end
                default: begin
                    mdl_be    = 4'(1 << (a % 4));
                    mdl_wdata = (w % 32'h100) * 32'h0101_0101;
                end
            endcase
        end else if (mdl_busy && mr) begin
            mdl_busy = 0;
        end
        mdl_exc = acc && op != 2'd3 && !legal;
        if (mdl_exc) mdl_pc = pc;
        @(posedge clk);
        #1;
        chk("m_valid", {31'b0, m_valid}, {31'b0, mdl_busy});
        if (mdl_busy) begin
            chk("m_addr", m_addr, mdl_addr);
            chk("m_wdata", m_wdata, mdl_wdata);
            chk("m_byteen", {28'b0, m_byteen}, {28'b0, mdl_be});
        end
        chk("exc_ades", {31'b0, exc_ades}, {31'b0, mdl_exc});
        if (mdl_exc) chk("exc_pc", exc_pc, mdl_pc);
        @(negedge clk);
    endtask

    task automatic idle(input bit mr);
        step(0, 2'd0, 32'h0, 32'h0, 32'h0, 0, mr);
    endtask

    initial begin
        logic [31:0] a;
        reset     = 1'b0;
        req_valid = 1'b0;
        store_op  = 2'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_pc    = 32'h0;
        flush     = 1'b0;
        m_ready   = 1'b0;
        model_reset();
        #2;
        chk("rst_m_valid", {31'b0, m_valid}, 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_m_byteen", {28'b0, m_byteen}, 32'h0);
        chk("rst_exc_ades", {31'b0, exc_ades}, 32'h0);
        chk("rst_exc_pc", exc_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // SB to 0x13 right after reset release, then back to idle.
        step(1, 2'd2, 32'h13, 32'h1234_56AB, 32'h100, 0, 1);
        chk("sb_byteen", {28'b0, m_byteen}, 32'h8);
        chk("sb_wdata", m_wdata, 32'hABAB_ABAB);
        idle(1);

        // SW held by back-pressure, then SH accepted back-to-back.
        step(1, 2'd0, 32'h100, 32'hDEAD_BEEF, 32'h104, 0, 0);
        step(1, 2'd1, 32'h202, 32'h0000_5A5A, 32'h108, 0, 0);
        step(1, 2'd1, 32'h202, 32'h0000_5A5A, 32'h108, 0, 0);
        step(1, 2'd1, 32'h202, 32'h0000_5A5A, 32'h108, 0, 0);
        step(1, 2'd1, 32'h202, 32'h0000_5A5A, 32'h108, 0, 1);
        chk("sh_byteen", {28'b0, m_byteen}, 32'hC);
        idle(1);
        idle(1);

        // Illegal stores.
        step(1, 2'd0, 32'h7F08, 32'h1, 32'h3000, 0, 1);
        chk("cnt_exc_pc", exc_pc, 32'h3000);
        idle(1);
        step(1, 2'd1, 32'h7F00, 32'h1, 32'h3004, 0, 1);
        step(1, 2'd0, 32'h3000, 32'h1, 32'h3008, 0, 1);
        step(1, 2'd0, 32'h2, 32'h1, 32'h300C, 0, 1);
        step(1, 2'd1, 32'h2, 32'h0000_1234, 32'h3010, 0, 1);
        idle(1);

        // Illegal store while a write drains; no-op op; flush.
        step(1, 2'd0, 32'h10, 32'h1111_2222, 32'h200, 0, 0);
        step(1, 2'd2, 32'h3000, 32'h1, 32'h204, 0, 1);
        step(1, 2'd3, 32'h20, 32'h1, 32'h208, 0, 1);
        step(1, 2'd0, 32'h40, 32'h1, 32'h20C, 1, 1);
        step(1, 2'd0, 32'h7F20, 32'h77, 32'h210, 0, 0);
        step(1, 2'd0, 32'h44, 32'h1, 32'h214, 1, 0);
        idle(1);

        // Reset while BUSY drops the write asynchronously.
        step(1, 2'd0, 32'h80, 32'hCAFE_F00D, 32'h300, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_m_valid", {31'b0, m_valid}, 32'h0);
        chk("async_m_byteen", {28'b0, m_byteen}, 32'h0);
        chk("async_m_addr", m_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(1, 2'd1, 32'h7F20, 32'h0000_ABCD, 32'h304, 0, 1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 'h3F));
                1:       a = 32'h2FF8 + 32'($urandom_range(0, 15));
                2:       a = 32'h7F00 + 32'($urandom_range(0, 'h2B));
                default: a = $urandom;
            endcase
            step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), a, $urandom,
                 $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
